// File: rtl/sdio_pkg.sv
// Shared types and constants for the SDIO transfer sequencer and its timer.
package sdio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE_PRE = 3'd1,
        ST_WAIT_PRE  = 3'd2,
        ST_ISSUE_CMD = 3'd3,
        ST_WAIT_CMD  = 3'd4,
        ST_DATA      = 3'd5,
        ST_BUSY      = 3'd6,
        ST_FINISH    = 3'd7
    } seq_state_e;

    typedef enum logic [1:0] {
        STOP_NONE     = 2'd0,
        STOP_AUTO     = 2'd1,
        STOP_PRE      = 2'd2,
        STOP_NONE_ALT = 2'd3
    } stop_mode_e;

    localparam logic [2:0] RSP_R1  = 3'h1;
    localparam logic [2:0] RSP_R1B = 3'h2;

    localparam logic [5:0] STOP_OP_DEF = 6'd12;
    localparam logic [5:0] PRE_OP_DEF  = 6'd23;

    // Status bit positions; the low four double as per-transfer error flags.
    localparam int unsigned STAT_CMD_ERR  = 0;
    localparam int unsigned STAT_DATA_ERR = 1;
    localparam int unsigned STAT_TIMEOUT  = 2;
    localparam int unsigned STAT_ABORT    = 3;
    localparam int unsigned STAT_BUSY     = 4;
    localparam int unsigned STAT_W        = 5;

    // Block count carried by the pre-count command: the field holds count minus one.
    function automatic logic [31:0] pre_count_arg(input logic [31:0] blk_num);
        return blk_num + 32'd1;
    endfunction

endpackage

// File: rtl/sdio_seq_timer.sv
// Loadable down-counter used as the per-transfer cycle budget.
// Counting stops at zero, and expire_o pulses in the cycle the count steps from one to zero,
// so a budget of zero never expires.
module sdio_seq_timer #(
    parameter int unsigned W = 24
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expire_o
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load has priority; otherwise decrement while enabled and not yet empty.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && !load_i && (cnt_q == ONE);

endmodule

// File: rtl/sdio_xfer_seq.sv
// Transfer sequencer: orders the command and data engines for one SDIO request at a time,
// with optional pre-count / auto-stop commands, R1b busy wait, timeout, abort and sticky status.
module sdio_xfer_seq
    import sdio_pkg::*;
#(
    parameter int unsigned BLK_NUM_W = 16,
    parameter int unsigned TO_W      = 24,
    parameter logic [5:0]  STOP_OP   = STOP_OP_DEF,
    parameter logic [5:0]  PRE_OP    = PRE_OP_DEF
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [5:0]           req_op_i,
    input  logic [31:0]          req_arg_i,
    input  logic [2:0]           req_rsp_type_i,
    input  logic                 req_data_en_i,
    input  logic                 req_rwn_i,
    input  logic [BLK_NUM_W-1:0] req_blk_num_i,
    input  logic [1:0]           req_stop_mode_i,
    input  logic [TO_W-1:0]      req_timeout_i,
    input  logic                 abort_i,
    input  logic                 clr_stat_i,
    output logic                 cmd_start_o,
    output logic [5:0]           cmd_op_o,
    output logic [31:0]          cmd_arg_o,
    output logic [2:0]           cmd_rsp_type_o,
    input  logic                 cmd_eot_i,
    input  logic                 cmd_err_i,
    input  logic                 data_go_i,
    output logic                 data_start_o,
    input  logic                 data_last_i,
    input  logic                 data_eot_i,
    input  logic                 data_err_i,
    input  logic                 dat0_i,
    output logic                 eng_abort_o,
    output logic                 eot_o,
    output logic                 err_o,
    output logic [7:0]           status_o
);

    seq_state_e state_q, state_d;

    logic [5:0]           op_q, op_d;
    logic [31:0]          arg_q, arg_d;
    logic [2:0]           rsp_q, rsp_d;
    logic                 data_en_q, data_en_d;
    logic                 rwn_q, rwn_d;
    logic [BLK_NUM_W-1:0] blk_num_q, blk_num_d;
    stop_mode_e           mode_q, mode_d;

    logic                 cmd_done_q, cmd_done_d;
    logic                 data_done_q, data_done_d;
    logic                 stop_pend_q, stop_pend_d;
    logic                 stop_req_q, stop_req_d;
    logic                 stop_done_q, stop_done_d;
    logic [3:0]           xfer_err_q, xfer_err_d;
    logic [STAT_W-1:0]    status_q, status_d;
    logic [STAT_W-1:0]    stat_set;

    logic        ready;
    logic        cmd_start;
    logic [5:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic [2:0]  cmd_rsp;
    logic        data_start;
    logic        eng_abort;
    logic        eot;
    logic        err;

    logic active;
    logic abort_hit;
    logic timer_load;
    logic timer_expire;
    logic stop_needed;
    logic stop_fire;

    assign active      = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign abort_hit   = active && abort_i;
    assign stop_needed = (mode_q == STOP_AUTO) && (blk_num_q != '0);

    sdio_seq_timer #(
        .W (TO_W)
    ) u_timer (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .load_i     (timer_load),
        .load_val_i (req_timeout_i),
        .en_i       (active),
        .expire_o   (timer_expire)
    );

    // Next-state, request latch, progress flags and engine strobes; abort beats timeout beats the rest.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        arg_d       = arg_q;
        rsp_d       = rsp_q;
        data_en_d   = data_en_q;
        rwn_d       = rwn_q;
        blk_num_d   = blk_num_q;
        mode_d      = mode_q;
        cmd_done_d  = cmd_done_q;
        data_done_d = data_done_q;
        stop_pend_d = stop_pend_q;
        stop_req_d  = stop_req_q;
        stop_done_d = stop_done_q;
        xfer_err_d  = xfer_err_q;
        stat_set    = '0;
        ready       = 1'b0;
        cmd_start   = 1'b0;
        cmd_op      = '0;
        cmd_arg     = '0;
        cmd_rsp     = '0;
        data_start  = 1'b0;
        eng_abort   = 1'b0;
        eot         = 1'b0;
        err         = 1'b0;
        timer_load  = 1'b0;
        stop_fire   = 1'b0;

        if (abort_hit) begin
            stat_set[STAT_ABORT] = 1'b1;
            state_d              = ST_FINISH;
        end else if (timer_expire) begin
            stat_set[STAT_TIMEOUT] = 1'b1;
            state_d                = ST_FINISH;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready = 1'b1;
                    if (req_valid_i) begin
                        op_d        = req_op_i;
                        arg_d       = req_arg_i;
                        rsp_d       = req_rsp_type_i;
                        data_en_d   = req_data_en_i;
                        rwn_d       = req_rwn_i;
                        blk_num_d   = req_blk_num_i;
                        mode_d      = stop_mode_e'(req_stop_mode_i);
                        cmd_done_d  = 1'b0;
                        data_done_d = 1'b0;
                        stop_pend_d = 1'b0;
                        stop_req_d  = 1'b0;
                        stop_done_d = 1'b0;
                        xfer_err_d  = '0;
                        timer_load  = 1'b1;
                        if (req_data_en_i && (stop_mode_e'(req_stop_mode_i) == STOP_PRE)) begin
                            state_d = ST_ISSUE_PRE;
                        end else begin
                            state_d = ST_ISSUE_CMD;
                        end
                    end
                end

                ST_ISSUE_PRE: begin
                    cmd_start = 1'b1;
                    cmd_op    = PRE_OP;
                    cmd_arg   = pre_count_arg(32'(blk_num_q));
                    cmd_rsp   = RSP_R1;
                    state_d   = ST_WAIT_PRE;
                end

                ST_WAIT_PRE: begin
                    if (cmd_eot_i) begin
                        if (cmd_err_i) begin
                            stat_set[STAT_CMD_ERR] = 1'b1;
                            state_d                = ST_FINISH;
                        end else begin
                            state_d = ST_ISSUE_CMD;
                        end
                    end
                end

                ST_ISSUE_CMD: begin
                    cmd_start = 1'b1;
                    cmd_op    = op_q;
                    cmd_arg   = arg_q;
                    cmd_rsp   = rsp_q;
                    state_d   = ST_WAIT_CMD;
                end

                ST_WAIT_CMD: begin
                    if (cmd_eot_i && cmd_err_i) begin
                        stat_set[STAT_CMD_ERR] = 1'b1;
                        state_d                = ST_FINISH;
                    end else if (data_en_q) begin
                        if (cmd_eot_i) begin
                            cmd_done_d = 1'b1;
                        end
                        if (data_go_i) begin
                            data_start = 1'b1;
                            state_d    = ST_DATA;
                        end
                    end else if (cmd_eot_i) begin
                        state_d = (rsp_q == RSP_R1B) ? ST_BUSY : ST_FINISH;
                    end
                end

                ST_DATA: begin
                    if (cmd_eot_i && cmd_err_i) begin
                        stat_set[STAT_CMD_ERR] = 1'b1;
                        state_d                = ST_FINISH;
                    end else if (data_eot_i && data_err_i) begin
                        stat_set[STAT_DATA_ERR] = 1'b1;
                        state_d                 = ST_FINISH;
                    end else begin
                        if (cmd_eot_i) begin
                            if (stop_pend_q) begin
                                stop_pend_d = 1'b0;
                            end else begin
                                cmd_done_d = 1'b1;
                            end
                        end
                        if (data_eot_i) begin
                            data_done_d = 1'b1;
                        end
                        // The stop command waits until the data command's own response is in.
                        if (stop_needed && !stop_done_q && (data_last_i || stop_req_q)) begin
                            if (cmd_done_q) begin
                                stop_fire   = 1'b1;
                                cmd_start   = 1'b1;
                                cmd_op      = STOP_OP;
                                cmd_arg     = '0;
                                cmd_rsp     = RSP_R1B;
                                stop_pend_d = 1'b1;
                                stop_done_d = 1'b1;
                                stop_req_d  = 1'b0;
                            end else begin
                                stop_req_d = 1'b1;
                            end
                        end
                        if (cmd_done_q && data_done_q && !stop_pend_q && !stop_req_q && !stop_fire) begin
                            if (!rwn_q && (stop_done_q || (rsp_q == RSP_R1B))) begin
                                state_d = ST_BUSY;
                            end else begin
                                state_d = ST_FINISH;
                            end
                        end
                    end
                end

                ST_BUSY: begin
                    if (dat0_i) begin
                        state_d = ST_FINISH;
                    end else begin
                        stat_set[STAT_BUSY] = 1'b1;
                    end
                end

                ST_FINISH: begin
                    eot       = 1'b1;
                    err       = |xfer_err_q;
                    eng_abort = xfer_err_q[STAT_TIMEOUT] | xfer_err_q[STAT_ABORT];
                    state_d   = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        xfer_err_d = xfer_err_d | stat_set[3:0];

        if (clr_stat_i) begin
            status_d = stat_set;
        end else begin
            status_d = status_q | stat_set;
        end
    end

    // State, request latch, flags and sticky status, all cleared by synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            arg_q       <= '0;
            rsp_q       <= '0;
            data_en_q   <= 1'b0;
            rwn_q       <= 1'b0;
            blk_num_q   <= '0;
            mode_q      <= STOP_NONE;
            cmd_done_q  <= 1'b0;
            data_done_q <= 1'b0;
            stop_pend_q <= 1'b0;
            stop_req_q  <= 1'b0;
            stop_done_q <= 1'b0;
            xfer_err_q  <= '0;
            status_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            arg_q       <= arg_d;
            rsp_q       <= rsp_d;
            data_en_q   <= data_en_d;
            rwn_q       <= rwn_d;
            blk_num_q   <= blk_num_d;
            mode_q      <= mode_d;
            cmd_done_q  <= cmd_done_d;
            data_done_q <= data_done_d;
            stop_pend_q <= stop_pend_d;
            stop_req_q  <= stop_req_d;
            stop_done_q <= stop_done_d;
            xfer_err_q  <= xfer_err_d;
            status_q    <= status_d;
        end
    end

    // Hold every output low while reset is asserted, even before the reset edge lands.
    always_comb begin
        req_ready_o    = rstn_i & ready;
        cmd_start_o    = rstn_i & cmd_start;
        cmd_op_o       = rstn_i ? cmd_op  : 6'd0;
        cmd_arg_o      = rstn_i ? cmd_arg : 32'd0;
        cmd_rsp_type_o = rstn_i ? cmd_rsp : 3'd0;
        data_start_o   = rstn_i & data_start;
        eng_abort_o    = rstn_i & eng_abort;
        eot_o          = rstn_i & eot;
        err_o          = rstn_i & err;
        status_o       = rstn_i ? {3'b000, status_q} : 8'h00;
    end

endmodule

// File: tb/tb_sdio_xfer_seq.sv
// Directed bench for sdio_xfer_seq: cycle-exact scenarios with hand-computed expectations.
module tb_sdio_xfer_seq;

    logic        clk_i;
    logic        rstn_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [5:0]  req_op_i;
    logic [31:0] req_arg_i;
    logic [2:0]  req_rsp_type_i;
    logic        req_data_en_i;
    logic        req_rwn_i;
    logic [15:0] req_blk_num_i;
    logic [1:0]  req_stop_mode_i;
    logic [23:0] req_timeout_i;
    logic        abort_i;
    logic        clr_stat_i;
    logic        cmd_start_o;
    logic [5:0]  cmd_op_o;
    logic [31:0] cmd_arg_o;
    logic [2:0]  cmd_rsp_type_o;
    logic        cmd_eot_i;
    logic        cmd_err_i;
    logic        data_go_i;
    logic        data_start_o;
    logic        data_last_i;
    logic        data_eot_i;
    logic        data_err_i;
    logic        dat0_i;
    logic        eng_abort_o;
    logic        eot_o;
    logic        err_o;
    logic [7:0]  status_o;

    int checks;
    int errors;

    sdio_xfer_seq dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_op_i        (req_op_i),
        .req_arg_i       (req_arg_i),
        .req_rsp_type_i  (req_rsp_type_i),
        .req_data_en_i   (req_data_en_i),
        .req_rwn_i       (req_rwn_i),
        .req_blk_num_i   (req_blk_num_i),
        .req_stop_mode_i (req_stop_mode_i),
        .req_timeout_i   (req_timeout_i),
        .abort_i         (abort_i),
        .clr_stat_i      (clr_stat_i),
        .cmd_start_o     (cmd_start_o),
        .cmd_op_o        (cmd_op_o),
        .cmd_arg_o       (cmd_arg_o),
        .cmd_rsp_type_o  (cmd_rsp_type_o),
        .cmd_eot_i       (cmd_eot_i),
        .cmd_err_i       (cmd_err_i),
        .data_go_i       (data_go_i),
        .data_start_o    (data_start_o),
        .data_last_i     (data_last_i),
        .data_eot_i      (data_eot_i),
        .data_err_i      (data_err_i),
        .dat0_i          (dat0_i),
        .eng_abort_o     (eng_abort_o),
        .eot_o           (eot_o),
        .err_o           (err_o),
        .status_o        (status_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not end, got timeout expected completion");
        $fatal(1);
    end

    task automatic clear_pulses();
        req_valid_i = 1'b0;
        abort_i     = 1'b0;
        clr_stat_i  = 1'b0;
        cmd_eot_i   = 1'b0;
        cmd_err_i   = 1'b0;
        data_go_i   = 1'b0;
        data_last_i = 1'b0;
        data_eot_i  = 1'b0;
        data_err_i  = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
        clear_pulses();
    endtask

    task automatic drive_req(input logic [5:0] op, input logic [31:0] arg, input logic [2:0] rsp,
                             input logic den, input logic rwn, input logic [15:0] blk,
                             input logic [1:0] mode, input logic [23:0] to);
        req_op_i        = op;
        req_arg_i       = arg;
        req_rsp_type_i  = rsp;
        req_data_en_i   = den;
        req_rwn_i       = rwn;
        req_blk_num_i   = blk;
        req_stop_mode_i = mode;
        req_timeout_i   = to;
        req_valid_i     = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            checks++; if (req_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready got %b exp 0", req_ready_o); end
            checks++; if (status_o !== 8'h00) begin errors++; $display("[TB] FAIL rst_status got %h exp 00", status_o); end
            checks++; if ({cmd_start_o, data_start_o, eot_o, eng_abort_o} !== 4'b0000) begin errors++; $display("[TB] FAIL rst_strobes got %b exp 0000", {cmd_start_o, data_start_o, eot_o, eng_abort_o}); end
            next_cycle();
        end
        rstn_i = 1'b1;
        @(negedge clk_i);
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_ready got %b exp 1", req_ready_o); end
    endtask

    task automatic test_single_read();
        next_cycle();
        drive_req(6'd17, 32'h0000_1000, 3'h1, 1'b1, 1'b1, 16'd0, 2'd0, 24'd0);
        @(negedge clk_i);
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rd_ready got %b exp 1", req_ready_o); end
        next_cycle();
        @(negedge clk_i);
        checks++; if ({cmd_start_o, cmd_op_o, cmd_arg_o, cmd_rsp_type_o} !== {1'b1, 6'd17, 32'h0000_1000, 3'h1}) begin errors++; $display("[TB] FAIL rd_cmd got %b/%0d/%h/%0d exp 1/17/1000/1", cmd_start_o, cmd_op_o, cmd_arg_o, cmd_rsp_type_o); end
        checks++; if (req_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL rd_busy_ready got %b exp 0", req_ready_o); end
        next_cycle();
        @(negedge clk_i);
        checks++; if (cmd_start_o !== 1'b0) begin errors++; $display("[TB] FAIL rd_single_pulse got %b exp 0", cmd_start_o); end
        next_cycle();
        cmd_eot_i = 1'b1;
        next_cycle();
        data_go_i = 1'b1;
        @(negedge clk_i);
        checks++; if (data_start_o !== 1'b1) begin errors++; $display("[TB] FAIL rd_data_start got %b exp 1", data_start_o); end
        next_cycle();
        data_last_i = 1'b1;
        @(negedge clk_i);
        checks++; if (cmd_start_o !== 1'b0) begin errors++; $display("[TB] FAIL rd_no_stop got %b exp 0", cmd_start_o); end
        next_cycle();
        data_eot_i = 1'b1;
        @(negedge clk_i);
        checks++; if (eot_o !== 1'b0) begin errors++; $display("[TB] FAIL rd_eot_early got %b exp 0", eot_o); end
        next_cycle();
        @(negedge clk_i);
        checks++; if (eot_o !== 1'b0) begin errors++; $display("[TB] FAIL rd_eot_early2 got %b exp 0", eot_o); end
        next_cycle();
        @(negedge clk_i);
        checks++; if ({eot_o, err_o, eng_abort_o} !== 3'b100) begin errors++; $display("[TB] FAIL rd_eot got %b exp 100", {eot_o, err_o, eng_abort_o}); end
        next_cycle();
        @(negedge clk_i);
        checks++; if ({eot_o, req_ready_o} !== 2'b01) begin errors++; $display("[TB] FAIL rd_back_to_idle got %b exp 01", {eot_o, req_ready_o}); end
    endtask

    task automatic test_write_auto_stop();
        int early;
        early = 0;
        next_cycle();
        drive_req(6'd25, 32'h0000_2000, 3'h1, 1'b1, 1'b0, 16'd3, 2'd1, 24'd0);
        next_cycle();
        @(negedge clk_i);
        checks++; if ({cmd_start_o, cmd_op_o} !== {1'b1, 6'd25}) begin errors++; $display("[TB] FAIL wr_cmd got %b/%0d exp 1/25", cmd_start_o, cmd_op_o); end
        next_cycle();
        cmd_eot_i = 1'b1;
        data_go_i = 1'b1;
        @(negedge clk_i);
        checks++; if (data_start_o !== 1'b1) begin errors++; $display("[TB] FAIL wr_data_start got %b exp 1", data_start_o); end
        next_cycle();
        next_cycle();
        data_last_i = 1'b1;
        @(negedge clk_i);
        checks++; if ({cmd_start_o, cmd_op_o, cmd_arg_o, cmd_rsp_type_o} !== {1'b1, 6'd12, 32'h0, 3'h2}) begin errors++; $display("[TB] FAIL wr_stop_cmd got %b/%0d/%h/%0d exp 1/12/0/2", cmd_start_o, cmd_op_o, cmd_arg_o, cmd_rsp_type_o); end
        next_cycle();
        @(negedge clk_i);
        checks++; if (cmd_start_o !== 1'b0) begin errors++; $display("[TB] FAIL wr_stop_pulse got %b exp 0", cmd_start_o); end
        next_cycle();
        cmd_eot_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            dat0_i = 1'b0;
            if (i == 0) data_eot_i = 1'b1;
            @(negedge clk_i);
            if (eot_o) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("[TB] FAIL wr_eot_during_busy got %0d exp 0", early); end
        next_cycle();
        dat0_i = 1'b1;
        @(negedge clk_i);
        checks++; if (eot_o !== 1'b0) begin errors++; $display("[TB] FAIL wr_eot_on_rise got %b exp 0", eot_o); end
        next_cycle();
        @(negedge clk_i);
        checks++; if ({eot_o, err_o} !== 2'b10) begin errors++; $display("[TB] FAIL wr_eot got %b exp 10", {eot_o, err_o}); end
        checks++; if (status_o !== 8'h10) begin errors++; $display("[TB] FAIL wr_status got %h exp 10", status_o); end
    endtask

    task automatic test_pre_count();
        int stops;
        stops = 0;
        next_cycle();
        drive_req(6'd18, 32'h0000_3000, 3'h1, 1'b1, 1'b1, 16'd7, 2'd2, 24'd0);
        clr_stat_i = 1'b1;
        next_cycle();
        @(negedge clk_i);
        checks++; if ({cmd_start_o, cmd_op_o, cmd_arg_o, cmd_rsp_type_o} !== {1'b1, 6'd23, 32'd8, 3'h1}) begin errors++; $display("[TB] FAIL pre_cmd23 got %b/%0d/%0d/%0d exp 1/23/8/1", cmd_start_o, cmd_op_o, cmd_arg_o, cmd_rsp_type_o); end
        next_cycle();
        cmd_eot_i = 1'b1;
        next_cycle();
        @(negedge clk_i);
        checks++; if ({cmd_start_o, cmd_op_o, cmd_arg_o} !== {1'b1, 6'd18, 32'h0000_3000}) begin errors++; $display("[TB] FAIL pre_cmd18 got %b/%0d/%h exp 1/18/3000", cmd_start_o, cmd_op_o, cmd_arg_o); end
        next_cycle();
        cmd_eot_i = 1'b1;
        data_go_i = 1'b1;
        @(negedge clk_i);
        checks++; if (data_start_o !== 1'b1) begin errors++; $display("[TB] FAIL pre_data_start got %b exp 1", data_start_o); end
        next_cycle();
        data_last_i = 1'b1;
        @(negedge clk_i);
        if (cmd_start_o) stops++;
        next_cycle();
        data_eot_i = 1'b1;
        @(negedge clk_i);
        if (cmd_start_o) stops++;
        next_cycle();
        @(negedge clk_i);
        if (cmd_start_o) stops++;
        checks++; if (stops !== 0) begin errors++; $display("[TB] FAIL pre_no_cmd12 got %0d exp 0", stops); end
        next_cycle();
        @(negedge clk_i);
        checks++; if ({eot_o, err_o, status_o} !== {2'b10, 8'h00}) begin errors++; $display("[TB] FAIL pre_eot got %b/%b/%h exp 1/0/00", eot_o, err_o, status_o); end
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        next_cycle();
        drive_req(6'd13, 32'h0001_0000, 3'h1, 1'b0, 1'b1, 16'd0, 2'd0, 24'd100);
        clr_stat_i = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            next_cycle();
            @(negedge clk_i);
            if (eot_o || eng_abort_o) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("[TB] FAIL to_early got %0d exp 0", early); end
        next_cycle();
        @(negedge clk_i);
        checks++; if ({eot_o, err_o, eng_abort_o} !== 3'b111) begin errors++; $display("[TB] FAIL to_finish got %b exp 111", {eot_o, err_o, eng_abort_o}); end
        checks++; if (status_o !== 8'h04) begin errors++; $display("[TB] FAIL to_status got %h exp 04", status_o); end
        next_cycle();
        @(negedge clk_i);
        checks++; if ({eng_abort_o, req_ready_o} !== 2'b01) begin errors++; $display("[TB] FAIL to_idle got %b exp 01", {eng_abort_o, req_ready_o}); end
    endtask

    task automatic test_abort();
        next_cycle();
        drive_req(6'd25, 32'h0000_4000, 3'h1, 1'b1, 1'b0, 16'd3, 2'd1, 24'd0);
        clr_stat_i = 1'b1;
        next_cycle();
        next_cycle();
        cmd_eot_i = 1'b1;
        data_go_i = 1'b1;
        next_cycle();
        next_cycle();
        data_last_i = 1'b1;
        abort_i     = 1'b1;
        @(negedge clk_i);
        checks++; if ({cmd_start_o, data_start_o} !== 2'b00) begin errors++; $display("[TB] FAIL ab_no_stop got %b exp 00", {cmd_start_o, data_start_o}); end
        next_cycle();
        @(negedge clk_i);
        checks++; if ({eot_o, err_o, eng_abort_o} !== 3'b111) begin errors++; $display("[TB] FAIL ab_finish got %b exp 111", {eot_o, err_o, eng_abort_o}); end
        checks++; if (status_o !== 8'h08) begin errors++; $display("[TB] FAIL ab_status got %h exp 08", status_o); end
    endtask

    task automatic test_reset_mid_data();
        next_cycle();
        drive_req(6'd17, 32'h0000_5000, 3'h1, 1'b1, 1'b1, 16'd0, 2'd0, 24'd0);
        next_cycle();
        next_cycle();
        cmd_eot_i = 1'b1;
        data_go_i = 1'b1;
        next_cycle();
        rstn_i = 1'b0;
        @(negedge clk_i);
        checks++; if ({req_ready_o, status_o} !== {1'b0, 8'h00}) begin errors++; $display("[TB] FAIL rm_in_reset got %b/%h exp 0/00", req_ready_o, status_o); end
        next_cycle();
        rstn_i = 1'b1;
        @(negedge clk_i);
        checks++; if ({req_ready_o, status_o} !== {1'b1, 8'h00}) begin errors++; $display("[TB] FAIL rm_idle got %b/%h exp 1/00", req_ready_o, status_o); end
        drive_req(6'd17, 32'h0000_6000, 3'h1, 1'b1, 1'b1, 16'd0, 2'd0, 24'd0);
        next_cycle();
        @(negedge clk_i);
        checks++; if ({cmd_start_o, cmd_op_o, cmd_arg_o} !== {1'b1, 6'd17, 32'h0000_6000}) begin errors++; $display("[TB] FAIL rm_new_cmd got %b/%0d/%h exp 1/17/6000", cmd_start_o, cmd_op_o, cmd_arg_o); end
        next_cycle();
        cmd_eot_i = 1'b1;
        data_go_i = 1'b1;
        @(negedge clk_i);
        checks++; if (data_start_o !== 1'b1) begin errors++; $display("[TB] FAIL rm_data_start got %b exp 1", data_start_o); end
        next_cycle();
        data_eot_i = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk_i);
        checks++; if ({eot_o, err_o, status_o} !== {2'b10, 8'h00}) begin errors++; $display("[TB] FAIL rm_eot got %b/%b/%h exp 1/0/00", eot_o, err_o, status_o); end
    endtask

    task automatic test_cmd_error();
        next_cycle();
        drive_req(6'd8, 32'h0000_01AA, 3'h1, 1'b0, 1'b1, 16'd0, 2'd0, 24'd0);
        next_cycle();
        next_cycle();
        cmd_eot_i = 1'b1;
        cmd_err_i = 1'b1;
        next_cycle();
        @(negedge clk_i);
        checks++; if ({eot_o, err_o, eng_abort_o} !== 3'b110) begin errors++; $display("[TB] FAIL ce_finish got %b exp 110", {eot_o, err_o, eng_abort_o}); end
        checks++; if (status_o !== 8'h01) begin errors++; $display("[TB] FAIL ce_status got %h exp 01", status_o); end
    endtask

    task automatic test_r1b_busy();
        next_cycle();
        drive_req(6'd7, 32'h0001_0000, 3'h2, 1'b0, 1'b1, 16'd0, 2'd0, 24'd0);
        clr_stat_i = 1'b1;
        next_cycle();
        @(negedge clk_i);
        checks++; if ({cmd_start_o, cmd_rsp_type_o} !== {1'b1, 3'h2}) begin errors++; $display("[TB] FAIL r1b_cmd got %b/%0d exp 1/2", cmd_start_o, cmd_rsp_type_o); end
        next_cycle();
        cmd_eot_i = 1'b1;
        dat0_i    = 1'b0;
        next_cycle();
        @(negedge clk_i);
        checks++; if (eot_o !== 1'b0) begin errors++; $display("[TB] FAIL r1b_wait got %b exp 0", eot_o); end
        next_cycle();
        dat0_i = 1'b1;
        @(negedge clk_i);
        checks++; if (eot_o !== 1'b0) begin errors++; $display("[TB] FAIL r1b_rise got %b exp 0", eot_o); end
        next_cycle();
        @(negedge clk_i);
        checks++; if ({eot_o, err_o, status_o} !== {2'b10, 8'h10}) begin errors++; $display("[TB] FAIL r1b_eot got %b/%b/%h exp 1/0/10", eot_o, err_o, status_o); end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rstn_i          = 1'b0;
        dat0_i          = 1'b1;
        req_op_i        = '0;
        req_arg_i       = '0;
        req_rsp_type_i  = '0;
        req_data_en_i   = 1'b0;
        req_rwn_i       = 1'b0;
        req_blk_num_i   = '0;
        req_stop_mode_i = '0;
        req_timeout_i   = '0;
        clear_pulses();
        $display("[TB] starting sdio_xfer_seq directed tests");
        test_reset();
        test_single_read();
        test_write_auto_stop();
        test_pre_count();
        test_timeout();
        test_abort();
        test_reset_mid_data();
        test_cmd_error();
        test_r1b_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
